// File: rtl/hamming_dec_engine.sv
// Hamming SECDED decoder engine: walks NUM_MSG 16-bit codewords in byte-wide
// data memory, corrects single-bit errors, flags double-bit errors and writes
// the recovered 11-bit data plus a 2-bit flag back as two result bytes.
module hamming_dec_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [3:0]        err1_cnt,
  output logic [3:0]        err2_cnt
);

  localparam int                IDX_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [7:0]        cw_lo_p0, cw_hi_p0;
  logic [7:0]        res_lo_p1, res_hi_p1;
  logic [15:0]       word_p0, fixed_p0;
  logic [3:0]        syn_p0;
  logic              par_p0;
  logic [1:0]        flag_p0;
  logic [15:0]       res_p0;
  logic              accept;

  // Syndrome: XOR of the Hamming positions of every set bit in 1..15.
  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) s = s ^ 4'(k);
    end
    return s;
  endfunction

  // Strip parity bits from a corrected word and prepend the flag: {hi, lo}.
  function automatic logic [15:0] pack_result(input logic [15:0] cw, input logic [1:0] f);
    logic [10:0] d;
    d = {cw[15:9], cw[7:5], cw[3]};
    return {f, 3'b000, d[10:8], d[7:0]};
  endfunction

  // Error counters stick at 15 rather than wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign src_addr = SRC_A + ADDR_W'({idx, 1'b0});
  assign dst_addr = DST_A + ADDR_W'({idx, 1'b0});
  assign word_p0  = {cw_hi_p0, cw_lo_p0};

  // Decode the captured codeword: syndrome, overall parity, correction, flag.
  always_comb begin
    syn_p0   = syndrome(word_p0);
    par_p0   = ^word_p0;
    fixed_p0 = word_p0;
    flag_p0  = 2'b00;
    if (par_p0) begin
      fixed_p0 = word_p0 ^ (16'd1 << syn_p0);
      flag_p0  = 2'b01;
    end else if (syn_p0 != 4'd0) begin
      flag_p0  = 2'b10;
    end
    res_p0 = pack_result(fixed_p0, flag_p0);
  end

  // Control state: FSM register, message index, status flags and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err1_cnt <= 4'd0;
      err2_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx      <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
        err1_cnt <= 4'd0;
        err2_cnt <= 4'd0;
      end
      if (state == DECODE) begin
        if (flag_p0 == 2'b01) err1_cnt <= sat_inc(err1_cnt);
        if (flag_p0 == 2'b10) err2_cnt <= sat_inc(err2_cnt);
      end
      if (state == WR_HI) begin
        if (idx == LAST_IDX) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Datapath capture: read bytes arrive one cycle after their address.
  always_ff @(posedge clk) begin
    if (state == RD_HI)  cw_lo_p0 <= mem_rdata;
    if (state == CAP_HI) cw_hi_p0 <= mem_rdata;
    // stage boundary: decoded result bytes held for the two write cycles
    if (state == DECODE) begin
      res_hi_p1 <= res_p0[15:8];
      res_lo_p1 <= res_p0[7:0];
    end
  end

  // Next-state and memory-port outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE, DONE: if (start) state_nxt = RD_LO;
      RD_LO: begin
        mem_addr  = src_addr;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = src_addr + ADDR_W'(1);
        state_nxt = CAP_HI;
      end
      CAP_HI: state_nxt = DECODE;
      DECODE: state_nxt = WR_LO;
      WR_LO: begin
        mem_addr  = dst_addr;
        mem_we    = 1'b1;
        mem_wdata = res_lo_p1;
        state_nxt = WR_HI;
      end
      WR_HI: begin
        mem_addr  = dst_addr + ADDR_W'(1);
        mem_we    = 1'b1;
        mem_wdata = res_hi_p1;
        state_nxt = (idx == LAST_IDX) ? DONE : RD_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: byte memory model, write scoreboard, vector
// tables, random encoded messages and control corner cases.
module tb_hamming_dec_engine;
  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 30;
  localparam int DST_BASE = 0;
  localparam int ADDR_W   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy, done;
  logic [3:0]        err1_cnt, err2_cnt;

  logic [7:0]        mem [0:255];
  logic              ld_we = 1'b0;
  logic [7:0]        ld_addr = '0;
  logic [7:0]        ld_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { logic [15:0] cw; logic [7:0] lo; logic [7:0] hi; } vec_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

  vec_t vecs [30];
  vec_t cur  [NUM_MSG];
  wr_t  sb   [$];

  always #5 clk = ~clk;

  hamming_dec_engine #(
    .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt)
  );

  // Synchronous byte memory, one-cycle read latency; bench preload port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (ld_we) mem[ld_addr] <= ld_data;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent SECDED encoder for 11-bit data.
  function automatic logic [15:0] encode(input logic [10:0] d);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] w;
    w = '0;
    for (int j = 0; j < 11; j++) w[pos[j]] = d[j];
    for (int b = 1; b < 16; b = b * 2) begin
      logic p;
      p = 1'b0;
      for (int q = 1; q < 16; q++) if ((q & b) != 0 && q != b) p = p ^ w[q];
      w[b] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = w[pos[j]];
    return d;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  endtask

  task automatic load_cur();
    for (int k = 0; k < NUM_MSG; k++) begin
      for (int b = 0; b < 2; b++) begin
        ld_addr = 8'(SRC_BASE + 2 * k + b);
        ld_data = (b == 1) ? cur[k].cw[15:8] : cur[k].cw[7:0];
        ld_we   = 1'b1;
        @(posedge clk); #1;
      end
    end
    ld_we = 1'b0;
  endtask

  task automatic push_expected();
    for (int k = 0; k < NUM_MSG; k++) begin
      sb.push_back('{8'(DST_BASE + 2 * k), cur[k].lo});
      sb.push_back('{8'(DST_BASE + 2 * k + 1), cur[k].hi});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Full run from the current memory contents; optional ignored start pulse.
  task automatic run_check(input string tag, input int restart_at);
    int e1, e2, n;
    e1 = 0; e2 = 0;
    for (int k = 0; k < NUM_MSG; k++) begin
      if (cur[k].hi[7:6] == 2'b01 && e1 < 15) e1++;
      if (cur[k].hi[7:6] == 2'b10 && e2 < 15) e2++;
    end
    push_expected();
    pulse_start();
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_done_start"}, 32'(done), 32'd0);
    check({tag, "_err1_clr"}, 32'(err1_cnt), 32'd0);
    check({tag, "_err2_clr"}, 32'(err2_cnt), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      start = (n == restart_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(6 * NUM_MSG));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_err1"}, 32'(err1_cnt), 32'(e1));
    check({tag, "_err2"}, 32'(err2_cnt), 32'(e2));
    check({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int n;
    vecs[0] = '{16'hFFFF, 8'hFF, 8'h07};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'h8000, 8'h00, 8'h40};
    vecs[3] = '{16'h0003, 8'h00, 8'h80};
    vecs[4] = '{16'h0001, 8'h00, 8'h40};
    for (int k = 0; k < 16; k++) vecs[5 + k]  = '{16'hFFFF ^ 16'(1 << k), 8'hFF, 8'h47};
    for (int k = 0; k < 9; k++)  vecs[21 + k] = '{16'h0000 ^ 16'(1 << k), 8'h00, 8'h40};

    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err1", 32'(err1_cnt), 32'd0);
    check("rst_err2", 32'(err2_cnt), 32'd0);
    reset = 1'b1;

    // Table-driven runs: fixed codewords and every single-bit flip.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_MSG; k++) cur[k] = vecs[r * NUM_MSG + k];
      load_cur();
      run_check(r == 0 ? "tbl0" : "tbl1", -1);
    end

    // Random messages with 0, 1 or 2 distinct bit flips.
    for (int k = 0; k < NUM_MSG; k++) begin
      logic [10:0] d;
      logic [15:0] w;
      int nf, b1, b2;
      d  = 11'($urandom_range(0, 2047));
      w  = encode(d);
      nf = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
      if (nf >= 1) w[b1] = ~w[b1];
      if (nf == 2) w[b2] = ~w[b2];
      if (nf == 2) d = extract(w);
      cur[k].cw = w;
      cur[k].lo = d[7:0];
      cur[k].hi = {(nf == 2) ? 2'b10 : (nf == 1) ? 2'b01 : 2'b00, 3'b000, d[10:8]};
    end
    load_cur();
    run_check("rand", -1);

    // Start while busy is ignored; then a start from DONE reruns cleanly.
    run_check("busy_start", 19);
    run_check("rerun", -1);

    // Reset asserted during a write cycle drops mem_we without a clock.
    push_expected();
    pulse_start();
    n = 0;
    while (mem_we !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_wr_lo", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b1;
    run_check("post_rst", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
